lcd_seq_ctrl: RTL and testbench
===============================

// Module: lcd_seq_ctrl
// PURPOSE
//  Sequencer for the LCD_dp datapath and the HD44780-style 8-bit LCD bus.
//  After power-up, issues the init command set, then continuously refreshes four BCD digits
//  (count3..count0) as ASCII, generating E/RS/RW timing.
//  Drives LCD_dp select lines; LCD_dp.DB_out goes to the LCD data pins.
// PARAMETERS
//  PWRUP_CYC  750000  clocks to wait after reset before first command (15 ms @ 50 MHz)
//  SETUP_CYC  2       clocks RS/DB stable before E rises (>=40 ns)
//  EHIGH_CYC  12      clocks E held high (>=230 ns)
//  HOLD_CYC   2       clocks DB/RS held after E falls (>=10 ns)
//  CMD_CYC    2000    post-write wait, normal command/data (40 us)
//  CLR_CYC    82000   post-write wait after clear 0x01 (1.64 ms)
//  GAP_CYC    500000  idle clocks between refresh frames (10 ms)
//  TMR_W      20      timer width; must hold max(all *_CYC)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-high reset
//  en         in   1  1 = allow next refresh frame to start; sampled only in GAP
//  init_sel   out  2  to LCD_dp.init_sel (11=0x38, 01=0x0E, 10=0x06, 00=0x01)
//  mux_sel    out  2  to LCD_dp.mux_sel (digit select)
//  data_sel   out  1  to LCD_dp.data_sel (1 = ASCII digit, 0 = command)
//  DB_sel     out  1  to LCD_dp.DB_sel (1 = drive byte, 0 = idle 0xCC)
//  lcd_e      out  1  LCD enable strobe
//  lcd_rs     out  1  LCD register select (= data_sel)
//  lcd_rw     out  1  LCD read/write; constant 0 (write only)
//  init_done  out  1  sticky 1 once first clear's wait completes
//  busy       out  1  1 in every state except GAP
// BEHAVIOUR
//  Reset (async, immediate): state=PWRUP, step=0, timer=PWRUP_CYC-1; lcd_e=0, lcd_rs=0,
//   lcd_rw=0, DB_sel=0, data_sel=0, init_sel=11, mux_sel=11, init_done=0, busy=1.
//  All outputs registered. Timer loads N-1 on state entry, decrements; exit on 0 => N clocks/state.
//  Step table (3-bit step):
//   0: cmd init_sel=11 (0x38)   1: cmd 01 (0x0E)   2: cmd 10 (0x06)   3: cmd 00 (0x01 clear)
//   4..7: data_sel=1, mux_sel=3,2,1,0 (count3 written first = leftmost)
//  States:
//   PWRUP -> SETUP after PWRUP_CYC.
//   SETUP: DB_sel=1, selects/RS from step, lcd_e=0; SETUP_CYC -> EHIGH.
//   EHIGH: lcd_e=1, all else held; EHIGH_CYC -> HOLD.
//   HOLD : lcd_e=0, DB/selects/RS held; HOLD_CYC -> WAIT.
//   WAIT : DB_sel=0, lcd_e=0; CLR_CYC if step==3 else CMD_CYC.
//          On exit: step 0..2,3..6 -> step+1, SETUP; step 7 -> GAP.
//          First exit from step 3 sets init_done (never cleared except by rst).
//   GAP  : busy=0, DB_sel=0; after GAP_CYC, if en=1 -> step=3, SETUP (frame = clear + 4 digits);
//          if en=0 stay in GAP (timer holds at 0) until en=1, then SETUP next clock.
//  Selects/RS change only on SETUP entry; never while lcd_e=1.
//  lcd_e high exactly EHIGH_CYC clocks per byte; one E pulse per step.
//  count0..3 not inputs here; LCD_dp samples them combinationally during SETUP..HOLD.
//  en ignored outside GAP; init sequence (steps 0-3) always runs fully after reset.
//  Reset mid-pulse: lcd_e drops asynchronously; full power-up wait + init re-run.
//  Frame length (steps 3-7) = 5*(SETUP+EHIGH+HOLD) + CLR_CYC + 4*CMD_CYC clocks.
// TESTING  (params scaled: PWRUP=20, SETUP=2, EHIGH=3, HOLD=1, CMD=5, CLR=10, GAP=8)
//  1 Reset, en=1 -> E low 20 clks; 4 E pulses, DB 0x38,0x0E,0x06,0x01, RS=0; init_done after clear wait.
//  2 count3..0=1,2,3,4 -> 4 pulses RS=1, DB 0x31,0x32,0x33,0x34, then busy=0 for 8 clks.
//  3 Check each byte: DB/RS stable 2 clks before E rise and 1 clk after fall; E high 3 clks.
//  4 en=0 in GAP for 50 clks -> no E pulses, busy=0; en=1 -> SETUP next clk, DB=0x01 first.
//  5 Assert rst while lcd_e=1 -> lcd_e=0 same cycle; 20-clk wait, init from 0x38, init_done=0.
//  6 Gap between E falls of clear and first digit = 1+10+2 clks (HOLD+CLR+SETUP), others 1+5+2.

Source files
------------

// File: rtl/lcd_seq_ctrl.sv
// lcd_seq_ctrl: sequencer for the LCD_dp datapath and an HD44780-style 8-bit bus.
// After reset it waits out the LCD power-up time, writes the init command set
// (function set, display on, entry mode, clear), then keeps rewriting the four
// BCD digits as ASCII in frames of "clear + 4 digits" separated by an idle gap.
// Every byte is one SETUP -> EHIGH -> HOLD -> WAIT pass; each state lasts
// exactly N clocks because the timer loads N-1 on entry and exits at zero.
module lcd_seq_ctrl #(
  parameter int PWRUP_CYC = 750000,
  parameter int SETUP_CYC = 2,
  parameter int EHIGH_CYC = 12,
  parameter int HOLD_CYC  = 2,
  parameter int CMD_CYC   = 2000,
  parameter int CLR_CYC   = 82000,
  parameter int GAP_CYC   = 500000,
  parameter int TMR_W     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] init_sel,
  output logic [1:0] mux_sel,
  output logic       data_sel,
  output logic       DB_sel,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       init_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_SETUP,
    S_EHIGH,
    S_HOLD,
    S_WAIT,
    S_GAP
  } state_t;

  // Timer reload values (N-1 gives exactly N clocks in the state).
  localparam logic [TMR_W-1:0] PWRUP_LD = TMR_W'(PWRUP_CYC - 1);
  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] EHIGH_LD = TMR_W'(EHIGH_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] CMD_LD   = TMR_W'(CMD_CYC - 1);
  localparam logic [TMR_W-1:0] CLR_LD   = TMR_W'(CLR_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);

  // Step 3 is the clear command; it needs the long post-write wait and its
  // completion marks the end of initialisation.
  localparam logic [2:0] STEP_CLR  = 3'd3;
  localparam logic [2:0] STEP_LAST = 3'd7;

  state_t           state;
  logic [2:0]       step;
  logic [TMR_W-1:0] timer;
  logic             tmr_zero;
  logic             enter_setup;
  logic [2:0]       nxt_step;

  // Command select for steps 0..3; data steps keep the clear code parked.
  function automatic logic [1:0] init_code(input logic [2:0] s);
    logic [1:0] code;
    if (s[2]) begin
      code = 2'b00;
    end else begin
      case (s[1:0])
        2'd0:    code = 2'b11;  // 0x38 function set
        2'd1:    code = 2'b01;  // 0x0E display on, cursor on
        2'd2:    code = 2'b10;  // 0x06 entry mode increment
        default: code = 2'b00;  // 0x01 clear
      endcase
    end
    return code;
  endfunction

  // Digit select: steps 4,5,6,7 -> count3,count2,count1,count0 (leftmost first).
  function automatic logic [1:0] digit_code(input logic [2:0] s);
    return s[2] ? ~s[1:0] : 2'b11;
  endfunction

  assign tmr_zero = (timer == '0);

  // Decide when the next byte's SETUP begins and which step it carries.
  always_comb begin
    enter_setup = 1'b0;
    nxt_step    = step;
    case (state)
      S_PWRUP: begin
        enter_setup = tmr_zero;
      end
      S_WAIT: begin
        if (tmr_zero && (step != STEP_LAST)) begin
          enter_setup = 1'b1;
          nxt_step    = step + 3'd1;
        end
      end
      S_GAP: begin
        if (tmr_zero && en) begin
          enter_setup = 1'b1;
          nxt_step    = STEP_CLR;
        end
      end
      default: begin
        enter_setup = 1'b0;
      end
    endcase
  end

  // Sequencer state, timer and all registered bus/select outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_PWRUP;
      step      <= 3'd0;
      timer     <= PWRUP_LD;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_rw    <= 1'b0;
      DB_sel    <= 1'b0;
      data_sel  <= 1'b0;
      init_sel  <= 2'b11;
      mux_sel   <= 2'b11;
      init_done <= 1'b0;
      busy      <= 1'b1;
    end else begin
      lcd_rw <= 1'b0;
      case (state)
        S_PWRUP: begin
          if (!tmr_zero) timer <= timer - TMR_W'(1);
        end
        S_SETUP: begin
          if (tmr_zero) begin
            state <= S_EHIGH;
            timer <= EHIGH_LD;
            lcd_e <= 1'b1;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        S_EHIGH: begin
          if (tmr_zero) begin
            state <= S_HOLD;
            timer <= HOLD_LD;
            lcd_e <= 1'b0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        S_HOLD: begin
          if (tmr_zero) begin
            state  <= S_WAIT;
            timer  <= (step == STEP_CLR) ? CLR_LD : CMD_LD;
            DB_sel <= 1'b0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        S_WAIT: begin
          if (tmr_zero) begin
            if (step == STEP_CLR) init_done <= 1'b1;
            if (step == STEP_LAST) begin
              state <= S_GAP;
              timer <= GAP_LD;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        S_GAP: begin
          // Timer parks at zero while en is low; exit is handled below.
          if (!tmr_zero) timer <= timer - TMR_W'(1);
        end
        default: begin
          state <= S_PWRUP;
          timer <= PWRUP_LD;
        end
      endcase

      // Selects and RS only ever change here, so they are settled well
      // before E rises and untouched while E is high.
      if (enter_setup) begin
        state    <= S_SETUP;
        step     <= nxt_step;
        timer    <= SETUP_LD;
        busy     <= 1'b1;
        DB_sel   <= 1'b1;
        data_sel <= nxt_step[2];
        lcd_rs   <= nxt_step[2];
        init_sel <= init_code(nxt_step);
        mux_sel  <= digit_code(nxt_step);
      end
    end
  end

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// tb_lcd_seq_ctrl: random-stimulus bench for lcd_seq_ctrl with scaled timing.
// The expected byte stream and timing come from a step-sequence model: pulse p
// maps to a step, each step has a known byte, RS and pre-pulse low interval.
module tb_lcd_seq_ctrl;
  localparam int PWRUP = 20;
  localparam int SETUP = 2;
  localparam int EHIGH = 3;
  localparam int HOLD  = 1;
  localparam int CMD   = 5;
  localparam int CLR   = 10;
  localparam int GAP   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [1:0] init_sel;
  logic [1:0] mux_sel;
  logic       data_sel;
  logic       DB_sel;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       init_done;
  logic       busy;

  lcd_seq_ctrl #(
    .PWRUP_CYC(PWRUP), .SETUP_CYC(SETUP), .EHIGH_CYC(EHIGH), .HOLD_CYC(HOLD),
    .CMD_CYC(CMD), .CLR_CYC(CLR), .GAP_CYC(GAP), .TMR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .init_sel(init_sel), .mux_sel(mux_sel), .data_sel(data_sel), .DB_sel(DB_sel),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int low_so_far = 0;
  int gap_exp = GAP;
  logic [3:0] count [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // LCD_dp stand-in: the byte that would appear on DB for the current selects.
  function automatic logic [7:0] dp_byte();
    logic [7:0] b;
    if (!DB_sel) b = 8'hCC;
    else if (data_sel) b = 8'h30 + {4'h0, count[mux_sel]};
    else begin
      case (init_sel)
        2'b11:   b = 8'h38;
        2'b01:   b = 8'h0E;
        2'b10:   b = 8'h06;
        default: b = 8'h01;
      endcase
    end
    return b;
  endfunction

  // Reference: pulse index after reset -> step (init 0..3, then frames 3..7).
  function automatic int step_of(input int p);
    return (p < 8) ? p : 3 + (p - 3) % 5;
  endfunction

  function automatic logic [7:0] exp_byte(input int step);
    logic [7:0] b;
    case (step)
      0: b = 8'h38;
      1: b = 8'h0E;
      2: b = 8'h06;
      3: b = 8'h01;
      default: b = 8'h30 + {4'h0, count[2'(7 - step)]};
    endcase
    return b;
  endfunction

  // Follow one byte transfer: low phase, E pulse, hold, and compare timing.
  task automatic do_byte(input int p, input int step, input int exp_low, input int exp_gap);
    int low, run, gap, high, hold, guard;
    logic [7:0] b, last_b, rb;
    logic last_rs, rrs;
    bit stable;
    low = low_so_far; run = 0; gap = 0; guard = 0;
    last_b = 8'hCC; last_rs = 1'b0;
    @(negedge clk);
    while (!lcd_e && guard < 2000) begin
      low++; guard++;
      if (!busy) gap++;
      b = dp_byte();
      if (DB_sel && run > 0 && b == last_b && lcd_rs == last_rs) run++;
      else run = DB_sel ? 1 : 0;
      last_b = b; last_rs = lcd_rs;
      @(negedge clk);
    end
    if (!lcd_e) begin
      check($sformatf("p%0d_e_rise_timeout", p), 32'(lcd_e), 32'd1);
      low_so_far = 0;
      return;
    end
    rb = dp_byte(); rrs = lcd_rs;
    if (rb != last_b || rrs != last_rs) run = 0;
    check($sformatf("p%0d_byte", p), 32'(rb), 32'(exp_byte(step)));
    check($sformatf("p%0d_rs", p), 32'(rrs), 32'(step >= 4));
    check($sformatf("p%0d_setup", p), 32'(run), 32'(SETUP));
    check($sformatf("p%0d_low", p), 32'(low), 32'(exp_low));
    check($sformatf("p%0d_gap", p), 32'(gap), 32'(exp_gap));
    check($sformatf("p%0d_init_done", p), 32'(init_done), 32'(p >= 4));
    check($sformatf("p%0d_rw_busy", p), {30'd0, lcd_rw, busy}, 32'd1);
    high = 0; stable = 1'b1;
    while (lcd_e && high < 100) begin
      high++;
      if (dp_byte() != rb || lcd_rs != rrs) stable = 1'b0;
      @(negedge clk);
    end
    check($sformatf("p%0d_ehigh", p), 32'(high), 32'(EHIGH));
    check($sformatf("p%0d_stable_e", p), 32'(stable), 32'd1);
    hold = 0;
    while (!lcd_e && DB_sel && dp_byte() == rb && lcd_rs == rrs && hold < 100) begin
      hold++;
      @(negedge clk);
    end
    check($sformatf("p%0d_hold", p), 32'(hold), 32'(HOLD));
    check($sformatf("p%0d_wait_idle", p), 32'(DB_sel), 32'd0);
    low_so_far = hold + 1;
  endtask

  // Raise en after it has been low for h gap clocks.
  task automatic en_release(input int h);
    int g;
    g = 0;
    @(negedge clk);
    while (busy && g < 500) begin g++; @(negedge clk); end
    repeat (h - 1) @(negedge clk);
    en = 1'b1;
  endtask

  task automatic run_seq(input int np, input bit force50);
    int step, prev, exp_low, exp_gap, h;
    for (int p = 0; p < np; p++) begin
      step = step_of(p);
      exp_gap = 0;
      if (p == 0) exp_low = PWRUP + SETUP;
      else begin
        prev = step_of(p - 1);
        exp_low = HOLD + SETUP + ((prev == 3) ? CLR : CMD);
        if (prev == 7) begin
          exp_low += gap_exp;
          exp_gap = gap_exp;
        end
      end
      if (step == 4) begin
        // en changes here are outside GAP; only its level in GAP matters.
        if ((force50 && p == 9) || $urandom_range(0, 1) == 1) begin
          h = (force50 && p == 9) ? 50 : int'($urandom_range(3, 30));
          en = 1'b0;
          gap_exp = (h > GAP) ? h : GAP;
          fork
            begin
              automatic int hh = h;
              en_release(hh);
            end
          join_none
        end else begin
          en = 1'b1;
          gap_exp = GAP;
        end
      end
      do_byte(p, step, exp_low, exp_gap);
      if (step == 3) begin
        if (p == 3) begin
          count[3] = 4'd1; count[2] = 4'd2; count[1] = 4'd3; count[0] = 4'd4;
        end else begin
          for (int i = 0; i < 4; i++) count[i] = 4'($urandom_range(0, 9));
        end
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check(tag, {22'd0, init_sel, mux_sel, data_sel, lcd_rs, lcd_e, lcd_rw, DB_sel, init_done},
          {22'd0, 2'b11, 2'b11, 6'b000000});
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) count[i] = 4'd0;
    en  = 1'($urandom_range(0, 1));
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset");
    rst = 1'b0;
    low_so_far = 0;
    run_seq(8 + 5 * 5, 1'b1);

    // Reset in the middle of an E pulse.
    begin
      int g;
      g = 0;
      @(negedge clk);
      while (!lcd_e && g < 2000) begin g++; @(negedge clk); end
      check("pre_rst_e_high", 32'(lcd_e), 32'd1);
      #2 rst = 1'b1;
      #1 check("rst_async_e_low", 32'(lcd_e), 32'd0);
      check("rst_async_init_done", 32'(init_done), 32'd0);
      repeat (2) @(posedge clk);
      #1 check_reset_state("reset_mid");
      @(posedge clk);
      #1 rst = 1'b0;
      low_so_far = 0;
    end
    run_seq(8 + 5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end
endmodule
